// File: rtl/popcount_pipe.sv
// Streaming masked popcount: pairwise adder tree with pipeline slices every REG_EVERY
// levels, bubble-collapsing valid/ready flow control and a per-frame running total.
module popcount_pipe #(
  parameter int NBITS     = 10,
  parameter int REG_EVERY = 2,
  parameter int ACCUM_W   = 16,
  localparam int LEVELS   = (NBITS > 1) ? $clog2(NBITS) : 1,
  localparam int STAGES   = (LEVELS + REG_EVERY - 1) / REG_EVERY,
  localparam int CNT_W    = $clog2(NBITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NBITS-1:0]   in_data,
  input  logic [NBITS-1:0]   in_mask,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_count,
  output logic [ACCUM_W-1:0] out_total,
  output logic               out_last
);

  localparam int TW = 2 ** LEVELS;

  logic [STAGES-1:0]  valid_q, last_q;
  logic [STAGES-1:0]  valid_in, last_in, stage_load, stage_en;
  logic [TW-1:0]      masked_w;
  logic [ACCUM_W-1:0] acc_q, total_q, total_d;

  assign masked_w = TW'(in_data & in_mask);

  // A stage may load when it is empty or everything downstream of it is moving.
  always_comb begin
    logic load_up;
    stage_load = '0;
    valid_in   = '0;
    last_in    = '0;
    load_up    = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      stage_load[s] = !valid_q[s] || load_up;
      load_up       = stage_load[s];
    end
    valid_in[0] = in_valid;
    last_in[0]  = in_last;
    for (int s = 1; s < STAGES; s++) begin
      valid_in[s] = valid_q[s-1];
      last_in[s]  = last_q[s-1];
    end
    stage_en = stage_load & valid_in;
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi <= LEVELS; gi++) begin : lv
      localparam int NN = 2 ** (LEVELS - gi);
      logic [gi:0] node [NN];
      if (gi == 0) begin : g_leaf
        for (gj = 0; gj < NN; gj++) begin : g_bit
          assign node[gj] = masked_w[gj];
        end
      end else begin : g_sum
        localparam int SI = (gi - 1) / REG_EVERY;
        logic [gi:0] psum [NN];
        // Each level is one bit wider than the last, so no partial sum can overflow.
        for (gj = 0; gj < NN; gj++) begin : g_add
          assign psum[gj] = {1'b0, lv[gi-1].node[2*gj]} + {1'b0, lv[gi-1].node[2*gj+1]};
        end
        if ((gi % REG_EVERY == 0) || (gi == LEVELS)) begin : g_reg
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              node <= '{default: '0};
            end else if (stage_en[SI]) begin
              node <= psum;
            end
          end
        end else begin : g_wire
          assign node = psum;
        end
      end
    end
  endgenerate

  assign total_d = acc_q + ACCUM_W'(lv[LEVELS].g_sum.psum[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      total_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (stage_load[s]) valid_q[s] <= valid_in[s];
        if (stage_en[s])   last_q[s]  <= last_in[s];
      end
      // A closing beat reports the full frame sum and leaves the accumulator empty.
      if (stage_en[STAGES-1]) begin
        total_q <= total_d;
        acc_q   <= last_in[STAGES-1] ? '0 : total_d;
      end
    end
  end

  assign in_ready  = stage_load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_last  = last_q[STAGES-1];
  assign out_count = CNT_W'(lv[LEVELS].node[0]);
  assign out_total = total_q;

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: directed and random beats checked every cycle against a
// frame-level reference model, plus literal expectations on captured outputs.
module tb_popcount_pipe;
  localparam int NBITS     = 10;
  localparam int REG_EVERY = 2;
  localparam int ACCUM_W   = 16;
  localparam int LEVELS    = $clog2(NBITS);
  localparam int STAGES    = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  typedef struct {
    int cnt;
    int tot;
    bit last;
    int cyc;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_last;
  logic [NBITS-1:0]   in_data, in_mask;
  logic               out_valid, out_ready, out_last;
  logic [3:0]         out_count;
  logic [ACCUM_W-1:0] out_total;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    model_acc = 0;
  bit    bp_rand  = 1'b0;
  beat_t exp_q[$];
  beat_t got[$];

  popcount_pipe #(.NBITS(NBITS), .REG_EVERY(REG_EVERY), .ACCUM_W(ACCUM_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mask(in_mask), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_total(out_total), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  function automatic void bound_fail(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout required completion", name);
  endfunction

  // Reference model: in-flight beats form a FIFO; the oldest one appears exactly
  // STAGES cycles after acceptance and the pipe refuses input only when full and stalled.
  always @(negedge clk) begin
    int    n;
    bit    exp_ov;
    beat_t b;
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      exp_q.delete();
      model_acc = 0;
    end else begin
      n = exp_q.size();
      chk("in_ready", 32'(in_ready), (n == STAGES && !out_ready) ? 0 : 1);
      exp_ov = 1'b0;
      if (n > 0) exp_ov = (cyc >= exp_q[0].cyc + STAGES);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("out_count", 32'(out_count), exp_q[0].cnt);
        chk("out_total", 32'(out_total), exp_q[0].tot);
        chk("out_last", 32'(out_last), 32'(exp_q[0].last));
      end
      if (out_valid && out_ready && exp_ov) begin
        got.push_back('{cnt: int'(out_count), tot: int'(out_total), last: out_last, cyc: cyc});
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        b.cnt  = $countones(in_data & in_mask);
        b.tot  = (model_acc + b.cnt) % (1 << ACCUM_W);
        b.last = in_last;
        b.cyc  = cyc;
        model_acc = b.last ? 0 : b.tot;
        exp_q.push_back(b);
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    if (bp_rand) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  task automatic send(input logic [NBITS-1:0] d, input logic [NBITS-1:0] m, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    in_last  = l;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    bound_fail("send");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    bound_fail("drain");
  endtask

  task automatic check_got(string name, int idx, int c, int t, bit l);
    if (idx >= got.size()) begin
      bound_fail(name);
      return;
    end
    chk({name, "_cnt"}, got[idx].cnt, c);
    chk({name, "_tot"}, got[idx].tot, t);
    chk({name, "_last"}, 32'(got[idx].last), 32'(l));
  endtask

  initial begin
    logic [NBITS-1:0] d, m;
    logic             l;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_last = 1'b0; out_ready = 1'b1;

    // reset state
    @(negedge clk);
    chk("reset_out_count", 32'(out_count), 0);
    chk("reset_out_total", 32'(out_total), 0);
    chk("reset_out_last", 32'(out_last), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // all ones, single-beat frame, latency
    got.delete();
    send(10'h3FF, 10'h3FF, 1'b1);
    for (int i = 0; i < STAGES - 1; i++) begin
      @(negedge clk);
      chk("latency_early", 32'(out_valid), 0);
    end
    @(negedge clk);
    chk("latency_hit", 32'(out_valid), 1);
    @(posedge clk); #1;
    drain();
    check_got("all_ones", 0, 10, 10, 1'b1);

    // masking
    got.delete();
    send(10'h3FF, 10'h155, 1'b1);
    send(10'h2AA, 10'h155, 1'b1);
    drain();
    check_got("mask_a", 0, 5, 5, 1'b1);
    check_got("mask_b", 1, 0, 0, 1'b1);

    // frame accumulation
    got.delete();
    send(10'h007, 10'h3FF, 1'b0);
    send(10'h07F, 10'h3FF, 1'b0);
    send(10'h3FF, 10'h3FF, 1'b1);
    send(10'h00F, 10'h3FF, 1'b1);
    drain();
    check_got("frame0", 0, 3, 3, 1'b0);
    check_got("frame1", 1, 7, 10, 1'b0);
    check_got("frame2", 2, 10, 20, 1'b1);
    check_got("frame3", 3, 4, 4, 1'b1);

    // zero mask still closes the frame
    got.delete();
    send(10'h00F, 10'h3FF, 1'b0);
    send(10'h3FF, 10'h000, 1'b1);
    send(10'h003, 10'h3FF, 1'b1);
    drain();
    check_got("zmask0", 0, 4, 4, 1'b0);
    check_got("zmask1", 1, 0, 4, 1'b1);
    check_got("zmask2", 2, 2, 2, 1'b1);

    // back-to-back burst
    got.delete();
    for (int i = 0; i < 8; i++) send(10'($urandom), 10'($urandom), i == 7);
    drain();
    chk("burst_size", got.size(), 8);
    for (int i = 1; i < 8 && i < got.size(); i++)
      chk("burst_consecutive", got[i].cyc - got[0].cyc, i);

    // backpressure
    got.delete();
    out_ready = 1'b0;
    send(10'h001, 10'h3FF, 1'b0);
    send(10'h003, 10'h3FF, 1'b0);
    in_valid = 1'b1; in_data = 10'h007; in_mask = 10'h3FF; in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold_count", 32'(out_count), 1);
      chk("bp_hold_total", 32'(out_total), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(10'h007, 10'h3FF, 1'b1);
    drain();
    chk("bp_size", got.size(), 3);
    check_got("bp0", 0, 1, 1, 1'b0);
    check_got("bp1", 1, 2, 3, 1'b0);
    check_got("bp2", 2, 3, 6, 1'b1);

    // reset with beats in flight and a partial frame sum of 7
    got.delete();
    send(10'h007, 10'h3FF, 1'b0);
    send(10'h00F, 10'h3FF, 1'b0);
    drain();
    check_got("pre_rst0", 0, 3, 3, 1'b0);
    check_got("pre_rst1", 1, 4, 7, 1'b0);
    out_ready = 1'b0;
    send(10'h001, 10'h3FF, 1'b0);
    send(10'h003, 10'h3FF, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_total", 32'(out_total), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    got.delete();
    send(10'h01F, 10'h3FF, 1'b1);
    drain();
    chk("post_rst_size", got.size(), 1);
    check_got("post_rst", 0, 5, 5, 1'b1);

    // random traffic with random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      d = 10'($urandom);
      m = ($urandom_range(0, 7) == 0) ? '0 : 10'($urandom);
      l = ($urandom_range(0, 3) == 0);
      send(d, m, l);
    end
    bp_rand = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(10'h3FF, 10'h3FF, 1'b1);
    drain();

    // long frame wraps the 16-bit accumulator
    got.delete();
    for (int i = 0; i < 6560; i++) send(10'h3FF, 10'h3FF, 1'b0);
    send(10'h3FF, 10'h3FF, 1'b1);
    drain();
    chk("wrap_size", got.size(), 6561);
    check_got("wrap_pre", 6552, 10, 65530, 1'b0);
    check_got("wrap_over", 6553, 10, 4, 1'b0);
    check_got("wrap_end", 6560, 10, 74, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
